// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/issue sequencer with branches, jumps, jal link and halt; PC_SEQ_STATS_EN adds a saturating taken counter
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [4:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        exec_valid,
  output logic [31:0] exec_instr,
  input  logic        exec_ready,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic [7:0]  taken_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] ir;
  logic [5:0] op;
  logic signed [31:0] a, b;
  logic is_br, is_j, is_jal, is_halt, cond, take;
  logic [4:0] pc_inc, pc_nxt;
  assign op = ir[31:26];
  assign a = rf_rdata1;
  assign b = rf_rdata2;
  assign pc_inc = pc + 5'd1;
  // decode the latched instruction and resolve the branch condition
  always_comb begin
    is_br   = op == 6'b000100 || op == 6'b000101 || op == 6'b000111 ||
              op == 6'b000001 || op == 6'b000011 || op == 6'b000110;
    is_j    = op == 6'b010100;
    is_jal  = op == 6'b010101;
    is_halt = op == 6'b111111;
    cond    = op == 6'b000100 ? a == b :
              op == 6'b000101 ? a != b :
              op == 6'b000111 ? a > b  :
              op == 6'b000001 ? a >= b :
              op == 6'b000011 ? a < b  :
              op == 6'b000110 ? a <= b : 1'b0;
    take    = state == DECODE && ((is_br && cond) || is_j || is_jal);
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = imem_ack ? DECODE : FETCH;
      DECODE:  state_nxt = is_halt ? HALT : (is_br || is_j || is_jal) ? FETCH : ISSUE;
      ISSUE:   state_nxt = exec_ready ? FETCH : ISSUE;
      default: state_nxt = HALT;
    endcase
  end
  // next pc: start clears, decode resolves control flow, issue acceptance advances
  always_comb begin
    pc_nxt = pc;
    if (state == IDLE && start) pc_nxt = '0;
    if (state == DECODE)
      pc_nxt = is_halt ? pc : (is_j || is_jal) ? ir[4:0] :
               (is_br && cond) ? pc_inc + ir[4:0] : is_br ? pc_inc : pc;
    if (state == ISSUE && exec_ready) pc_nxt = pc_inc;
  end
  // pc and instruction register
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      pc <= pc_nxt;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
    end
  // strobes and status are pure functions of state and the latched instruction
  always_comb begin
    imem_req   = state == FETCH;
    exec_valid = state == ISSUE;
    rf_we      = state == DECODE && is_jal;
    busy       = state == FETCH || state == DECODE || state == ISSUE;
    halted     = state == HALT;
  end
  assign imem_addr  = pc;
  assign rf_raddr1  = ir[25:21];
  assign rf_raddr2  = ir[20:16];
  assign rf_waddr   = 5'd31;
  assign rf_wdata   = {27'd0, pc_inc};
  assign exec_instr = ir;
`ifdef PC_SEQ_STATS_EN
  logic [7:0] cnt;
  // saturating count of taken branches and jumps
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (take && cnt != 8'hff) cnt <= cnt + 8'd1;
  assign taken_count = cnt;
`else
  logic unused_take;
  assign unused_take = take;
  assign taken_count = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 0, rst = 1, start = 0, imem_ack = 0, exec_ready = 0;
  logic [31:0] imem_rdata = 0, rf_rdata1, rf_rdata2, rf_wdata, exec_instr;
  logic imem_req, rf_we, exec_valid, busy, halted;
  logic [4:0] imem_addr, rf_raddr1, rf_raddr2, rf_waddr, pc;
  logic [7:0] taken_count;
  int n = 0, errs = 0, ec = 0;
  pc_sequencer dut (.clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_ready(exec_ready), .pc(pc), .busy(busy),
    .halted(halted), .taken_count(taken_count));
  always #5 clk = ~clk;
  function automatic logic [31:0] rf(input logic [4:0] r);
    return r == 5'd16 ? 32'd4 : r == 5'd17 ? 32'd2 : 32'd0;
  endfunction
  assign rf_rdata1 = rf(rf_raddr1);
  assign rf_rdata2 = rf(rf_raddr2);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_cnt;
`ifdef PC_SEQ_STATS_EN
    return ec;
`else
    return 0;
`endif
  endfunction
  task automatic fetch(input logic [31:0] ins);
    int w = 0;
    while (!imem_req && w < 8) begin
      tick;
      w++;
    end
    chk("fetch_req", {31'd0, imem_req}, 1);
    imem_ack = 1;
    imem_rdata = ins;
    tick;
    imem_ack = 0;
    imem_rdata = 0;
    chk("decode_flags", {busy, imem_req, exec_valid}, 32'b100);
  endtask
  task automatic ctrl(input string tag, input logic [31:0] ins, input logic [4:0] exp_pc, input bit tk);
    fetch(ins);
    tick;
    if (tk) ec++;
    chk(tag, {27'd0, pc}, {27'd0, exp_pc});
    chk("taken_count", {24'd0, taken_count}, exp_cnt());
    chk("refetch", {31'd0, imem_req}, 1);
  endtask
  initial begin
    tick;
    chk("rst_state", {pc, imem_req, rf_we, exec_valid, busy, halted}, 0);
    chk("rst_cnt", {24'd0, taken_count}, 0);
    rst = 0;
    start = 1;
    tick;
    start = 0;
    chk("start", {pc, imem_req, busy}, {5'd0, 2'b11});
    tick;
    chk("req_hold", {31'd0, imem_req}, 1);
    ctrl("j5", {6'b010100, 21'd0, 5'd5}, 5'd5, 1);
    ctrl("beq_taken", {6'b000100, 5'd16, 5'd16, 16'd3}, 5'd9, 1);
    ctrl("j5b", {6'b010100, 21'd0, 5'd5}, 5'd5, 1);
    ctrl("bgt_nt", {6'b000111, 5'd17, 5'd16, 16'd3}, 5'd6, 0);
    ctrl("j5c", {6'b010100, 21'd0, 5'd5}, 5'd5, 1);
    ctrl("bgt_t", {6'b000111, 5'd16, 5'd17, 16'd3}, 5'd9, 1);
    ctrl("j7", {6'b010100, 21'd0, 5'd7}, 5'd7, 1);
    fetch({6'b010101, 21'd0, 5'd20});
    chk("jal_we", {rf_we, rf_waddr, rf_wdata[26:0]}, {1'b1, 5'd31, 27'd8});
    chk("jal_wdata_hi", {27'd0, rf_wdata[31:27]}, 0);
    tick;
    ec++;
    chk("jal_pc", {26'd0, rf_we, pc}, {27'd0, 5'd20});
    fetch(32'h0000_1234);
    chk("alu_decode_ev", {31'd0, exec_valid}, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      exec_ready = i == 3;
      chk("issue_flags", {exec_valid, imem_req, pc}, {1'b1, 1'b0, 5'd20});
      chk("issue_instr", exec_instr, 32'h0000_1234);
      tick;
    end
    exec_ready = 0;
    chk("issue_done", {exec_valid, imem_req, pc}, {1'b0, 1'b1, 5'd21});
    ctrl("j30", {6'b010100, 21'd0, 5'd30}, 5'd30, 1);
    ctrl("bne_wrap", {6'b000101, 5'd16, 5'd17, 16'd1}, 5'd0, 1);
    ctrl("beq_self", {6'b000100, 5'd0, 5'd0, 16'hffff}, 5'd0, 1);
    chk("self_addr", {27'd0, imem_addr}, 0);
    rst = 1;
    tick;
    rst = 0;
    ec = 0;
    chk("mid_rst", {pc, imem_req, busy, halted}, 0);
    chk("mid_rst_cnt", {24'd0, taken_count}, 0);
    start = 1;
    tick;
    start = 0;
    ctrl("j3", {6'b010100, 21'd0, 5'd3}, 5'd3, 1);
    fetch(32'hfc00_0000);
    tick;
    chk("halt", {pc, halted, busy, imem_req}, {5'd3, 3'b100});
    start = 1;
    imem_ack = 1;
    tick;
    tick;
    start = 0;
    imem_ack = 0;
    chk("halt_stay", {pc, halted, busy, imem_req}, {5'd3, 3'b100});
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
